board_store: RTL and testbench

Holds the 15×15 Gobang board state and is the write side of the cursor/seat path. It accepts move commands (place, erase, clear) from the PS-side AXI register block, checks them against the current board, and commits them. It also serves a registered read port that the VGA renderer uses to look up the piece at any seat. The seat coordinates use the same 4-bit board encoding that the cursor decoder produces.

---
 rtl/board_store.sv | 199 +++++++++++++++++++
 tb/tb_board_store.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_store.sv
// board_store: 15x15 Gobang board, checked PLACE/ERASE/CLEAR commit path plus renderer read port.
// Latency: NOP/PLACE/ERASE done 2 cycles after transfer; CLEAR done 225 cycles after; read port 1 cycle.
// Backpressure: cmd_ready_o high only in IDLE, one command in flight; rd port never stalls.
module board_store #(
    parameter int BOARD_N = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [3:0] seat_x_i,
    input  logic [3:0] seat_y_i,
    input  logic [1:0] piece_i,
    output logic       done_o,
    output logic       err_o,
    input  logic [3:0] rd_x_i,
    input  logic [3:0] rd_y_i,
    output logic [1:0] rd_piece_o,
    output logic [7:0] piece_count_o,
    output logic [3:0] last_x_o,
    output logic [3:0] last_y_o,
    output logic       last_valid_o
);
    localparam int         CELLS     = BOARD_N * BOARD_N;
    localparam logic [7:0] LAST_ADDR = 8'(CELLS - 1);
    localparam logic [3:0] N4        = 4'(BOARD_N);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_PLACE = 2'd1,
        OP_ERASE = 2'd2,
        OP_CLEAR = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COMMIT,
        S_CLEAR,
        S_DONE
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] piece;
    } cmd_t;

    state_e     state_q, state_d;
    cmd_t       cmd_q;
    logic [7:0] sweep_q;
    logic       from_rst_q;
    logic       err_q;

    logic [1:0] mem [0:CELLS-1];

    logic       xfer;
    logic       tgt_in, rd_in, check_err;
    logic [7:0] tgt_addr, rd_addr;
    logic [1:0] tgt_cell;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [1:0] mem_wdata;

    function automatic logic [7:0] cell_addr(input logic [3:0] x, input logic [3:0] y);
        return {4'd0, y} * 8'(BOARD_N) + {4'd0, x};
    endfunction

    assign xfer     = cmd_valid_i && cmd_ready_o;
    assign tgt_in   = (cmd_q.x < N4) && (cmd_q.y < N4);
    assign tgt_addr = cell_addr(cmd_q.x, cmd_q.y);
    assign tgt_cell = tgt_in ? mem[tgt_addr] : 2'd0;

    always_comb begin
        check_err = 1'b0;
        case (cmd_q.op)
            OP_PLACE: check_err = !tgt_in || (cmd_q.piece == 2'd0) || (cmd_q.piece == 2'd3)
                                  || (tgt_cell != 2'd0);
            OP_ERASE: check_err = !tgt_in || (tgt_cell == 2'd0);
            default:  check_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        done_o      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = tgt_addr;
        mem_wdata   = 2'd0;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = (op_e'(cmd_op_i) == OP_CLEAR) ? S_CLEAR : S_CHECK;
                end
            end
            S_CHECK: state_d = S_COMMIT;
            S_COMMIT: begin
                if (!err_q && (cmd_q.op == OP_PLACE || cmd_q.op == OP_ERASE)) begin
                    mem_we    = 1'b1;
                    mem_wdata = (cmd_q.op == OP_PLACE) ? cmd_q.piece : 2'd0;
                end
                state_d = S_DONE;
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                // Reset-initiated sweeps return silently; commanded ones report completion.
                if (sweep_q == LAST_ADDR) begin
                    state_d = from_rst_q ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_o = done_o && err_q;

    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q         <= '0;
            sweep_q       <= 8'd0;
            from_rst_q    <= 1'b1;
            err_q         <= 1'b0;
            piece_count_o <= 8'd0;
            last_x_o      <= 4'd0;
            last_y_o      <= 4'd0;
            last_valid_o  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (xfer) begin
                        cmd_q      <= '{op: op_e'(cmd_op_i), x: seat_x_i, y: seat_y_i, piece: piece_i};
                        sweep_q    <= 8'd0;
                        from_rst_q <= 1'b0;
                        err_q      <= 1'b0;
                    end
                end
                S_CHECK: err_q <= check_err;
                S_COMMIT: begin
                    if (!err_q) begin
                        if (cmd_q.op == OP_PLACE) begin
                            piece_count_o <= piece_count_o + 8'd1;
                            last_x_o      <= cmd_q.x;
                            last_y_o      <= cmd_q.y;
                            last_valid_o  <= 1'b1;
                        end else if (cmd_q.op == OP_ERASE) begin
                            piece_count_o <= piece_count_o - 8'd1;
                            if (cmd_q.x == last_x_o && cmd_q.y == last_y_o) begin
                                last_valid_o <= 1'b0;
                            end
                        end
                    end
                end
                S_CLEAR: begin
                    sweep_q <= sweep_q + 8'd1;
                    if (sweep_q == LAST_ADDR) begin
                        piece_count_o <= 8'd0;
                        last_valid_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Renderer port: reads the pre-write contents when port A writes the same cell this edge.
    assign rd_in   = (rd_x_i < N4) && (rd_y_i < N4);
    assign rd_addr = cell_addr(rd_x_i, rd_y_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_piece_o <= 2'd0;
        end else begin
            rd_piece_o <= rd_in ? mem[rd_addr] : 2'd0;
        end
    end
endmodule

// File: tb/tb_board_store.sv
// Self-checking bench for board_store: directed vector table, hand sequences, random vs board model.
module tb_board_store;
    localparam logic [1:0] NOP = 2'd0, PLACE = 2'd1, ERASE = 2'd2, CLEAR = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [1:0] cmd_op_i = 2'd0;
    logic [3:0] seat_x_i = 4'd0;
    logic [3:0] seat_y_i = 4'd0;
    logic [1:0] piece_i = 2'd0;
    logic       done_o;
    logic       err_o;
    logic [3:0] rd_x_i = 4'd0;
    logic [3:0] rd_y_i = 4'd0;
    logic [1:0] rd_piece_o;
    logic [7:0] piece_count_o;
    logic [3:0] last_x_o;
    logic [3:0] last_y_o;
    logic       last_valid_o;

    always #5 clk = ~clk;

    board_store #(.BOARD_N(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .seat_x_i     (seat_x_i),
        .seat_y_i     (seat_y_i),
        .piece_i      (piece_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .rd_x_i       (rd_x_i),
        .rd_y_i       (rd_y_i),
        .rd_piece_o   (rd_piece_o),
        .piece_count_o(piece_count_o),
        .last_x_o     (last_x_o),
        .last_y_o     (last_y_o),
        .last_valid_o (last_valid_o)
    );

    typedef struct {
        logic [1:0] op;
        int         x;
        int         y;
        int         p;
        int         e;
        int         cnt;
        int         rd;
        int         lv;
        int         lx;
        int         ly;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference board, indexed [row][column]; occupancy count is derived, never tracked.
    int mdl [15][15];
    int m_lx, m_ly, m_lv;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic mdl_zero();
        for (int yy = 0; yy < 15; yy++)
            for (int xx = 0; xx < 15; xx++)
                mdl[yy][xx] = 0;
    endtask

    function automatic int mdl_count();
        int n;
        n = 0;
        for (int yy = 0; yy < 15; yy++)
            for (int xx = 0; xx < 15; xx++)
                if (mdl[yy][xx] != 0) n++;
        return n;
    endfunction

    function automatic int mdl_cell(input int x, input int y);
        if (x < 15 && y < 15) return mdl[y][x];
        return 0;
    endfunction

    task automatic mdl_apply(input logic [1:0] op, input int x, input int y, input int p,
                             output int e);
        int inr;
        inr = (x < 15 && y < 15) ? 1 : 0;
        e = 0;
        case (op)
            PLACE: begin
                if (inr == 0 || (p != 1 && p != 2)) e = 1;
                else if (mdl[y][x] != 0) e = 1;
                else begin
                    mdl[y][x] = p;
                    m_lx = x; m_ly = y; m_lv = 1;
                end
            end
            ERASE: begin
                if (inr == 0) e = 1;
                else if (mdl[y][x] == 0) e = 1;
                else begin
                    mdl[y][x] = 0;
                    if (x == m_lx && y == m_ly) m_lv = 0;
                end
            end
            CLEAR: begin
                mdl_zero();
                m_lv = 0;
            end
            default: ;
        endcase
    endtask

    task automatic mdl_reset();
        mdl_zero();
        m_lv = 0; m_lx = 0; m_ly = 0;
    endtask

    // Entered and left just after a falling edge; lat counts rising edges from transfer to done.
    task automatic do_cmd(input logic [1:0] op, input int x, input int y, input int p,
                          output int err, output int lat);
        int guard;
        guard = 0;
        err = -1;
        lat = -1;
        while (cmd_ready_o !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            chk("cmd_ready_timeout", guard, 0);
            return;
        end
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        seat_x_i    = 4'(x);
        seat_y_i    = 4'(y);
        piece_i     = 2'(p);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        chk("ready_low_busy", int'(cmd_ready_o), 0);
        lat = 0;
        while (done_o !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        err = int'(err_o);
        @(negedge clk);
        chk("done_one_cycle", int'(done_o), 0);
        chk("ready_after_done", int'(cmd_ready_o), 1);
    endtask

    task automatic read_cell(input int x, input int y, output int v);
        rd_x_i = 4'(x);
        rd_y_i = 4'(y);
        @(negedge clk);
        v = int'(rd_piece_o);
    endtask

    task automatic scan_board(input string name);
        int v;
        for (int yy = 0; yy < 15; yy++)
            for (int xx = 0; xx < 15; xx++) begin
                read_cell(xx, yy, v);
                chk(name, v, mdl[yy][xx]);
            end
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ready"}, int'(cmd_ready_o), 0);
        chk({name, "_done"}, int'(done_o), 0);
        chk({name, "_err"}, int'(err_o), 0);
        chk({name, "_rd"}, int'(rd_piece_o), 0);
        chk({name, "_count"}, int'(piece_count_o), 0);
        chk({name, "_last_x"}, int'(last_x_o), 0);
        chk({name, "_last_y"}, int'(last_y_o), 0);
        chk({name, "_last_valid"}, int'(last_valid_o), 0);
    endtask

    task automatic release_and_sweep(input string name);
        int cyc, dones;
        rst_n = 1'b1;
        cyc = 0;
        dones = 0;
        while (cmd_ready_o !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (done_o === 1'b1) dones++;
        end
        chk({name, "_sweep_cycles"}, cyc, 225);
        chk({name, "_sweep_done_pulses"}, dones, 0);
        chk({name, "_sweep_count"}, int'(piece_count_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checked", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl [13];
        int   e, me, lat, v, cyc, dones, xfer, drop;
        int   r, op, x, y, p, rx, ry;

        tbl[0]  = '{PLACE,  7,  7, 1, 0, 1, 1, 1,  7,  7};
        tbl[1]  = '{PLACE,  7,  7, 2, 1, 1, 1, 1,  7,  7};
        tbl[2]  = '{PLACE, 15,  3, 1, 1, 1, 0, 1,  7,  7};
        tbl[3]  = '{PLACE,  4,  4, 3, 1, 1, 0, 1,  7,  7};
        tbl[4]  = '{PLACE,  4,  4, 0, 1, 1, 0, 1,  7,  7};
        tbl[5]  = '{NOP,    4,  4, 0, 0, 1, 0, 1,  7,  7};
        tbl[6]  = '{ERASE,  7,  7, 0, 0, 0, 0, 0,  0,  0};
        tbl[7]  = '{ERASE,  7,  7, 0, 1, 0, 0, 0,  0,  0};
        tbl[8]  = '{ERASE,  3, 15, 0, 1, 0, 0, 0,  0,  0};
        tbl[9]  = '{PLACE,  0,  0, 1, 0, 1, 1, 1,  0,  0};
        tbl[10] = '{PLACE, 14, 14, 2, 0, 2, 2, 1, 14, 14};
        tbl[11] = '{ERASE,  0,  0, 0, 0, 1, 0, 1, 14, 14};
        tbl[12] = '{NOP,   15, 15, 0, 0, 1, 0, 1, 14, 14};

        // Power-on reset and the silent sweep that follows it.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        mdl_reset();
        release_and_sweep("rst");
        scan_board("rst_board");

        for (int i = 0; i < 13; i++) begin
            do_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].p, e, lat);
            mdl_apply(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].p, me);
            chk($sformatf("vec%0d_err", i), e, tbl[i].e);
            chk($sformatf("vec%0d_latency", i), lat, 2);
            chk($sformatf("vec%0d_count", i), int'(piece_count_o), tbl[i].cnt);
            chk($sformatf("vec%0d_last_valid", i), int'(last_valid_o), tbl[i].lv);
            if (tbl[i].lv != 0) begin
                chk($sformatf("vec%0d_last_x", i), int'(last_x_o), tbl[i].lx);
                chk($sformatf("vec%0d_last_y", i), int'(last_y_o), tbl[i].ly);
            end
            read_cell(tbl[i].x, tbl[i].y, v);
            chk($sformatf("vec%0d_cell", i), v, tbl[i].rd);
        end

        // Read the cell in the same edge COMMIT writes it: old value first, new value next.
        rd_x_i = 4'd3;
        rd_y_i = 4'd9;
        cmd_valid_i = 1'b1;
        cmd_op_i = PLACE;
        seat_x_i = 4'd3;
        seat_y_i = 4'd9;
        piece_i = 2'd2;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rdw_old_value", int'(rd_piece_o), 0);
        chk("rdw_done", int'(done_o), 1);
        chk("rdw_err", int'(err_o), 0);
        @(negedge clk);
        chk("rdw_new_value", int'(rd_piece_o), 2);
        mdl_apply(PLACE, 3, 9, 2, me);

        do_cmd(PLACE, 0, 0, 1, e, lat);
        mdl_apply(PLACE, 0, 0, 1, me);
        chk("fill_count", int'(piece_count_o), 3);

        do_cmd(CLEAR, 0, 0, 0, e, lat);
        mdl_apply(CLEAR, 0, 0, 0, me);
        chk("clear_latency", lat, 225);
        chk("clear_err", e, 0);
        chk("clear_count", int'(piece_count_o), 0);
        chk("clear_last_valid", int'(last_valid_o), 0);
        scan_board("clear_board");
        read_cell(14, 15, v);
        chk("read_out_of_range", v, 0);

        // Reset in the middle of a commanded CLEAR restarts a silent sweep.
        do_cmd(PLACE, 0, 0, 1, e, lat);
        mdl_apply(PLACE, 0, 0, 1, me);
        do_cmd(PLACE, 14, 14, 2, e, lat);
        mdl_apply(PLACE, 14, 14, 2, me);
        cmd_valid_i = 1'b1;
        cmd_op_i = CLEAR;
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (50) @(negedge clk);
        read_cell(0, 0, v);
        chk("clear_partial_front", v, 0);
        read_cell(14, 14, v);
        chk("clear_partial_back", v, 2);
        rst_n = 1'b0;
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        chk("midclear_reset_done", dones, 0);
        check_reset_outputs("midclear_rst");
        mdl_reset();
        release_and_sweep("midclear");
        scan_board("midclear_board");

        // Valid held high while the block is busy must transfer exactly once.
        cmd_valid_i = 1'b1;
        cmd_op_i = CLEAR;
        @(negedge clk);
        mdl_apply(CLEAR, 0, 0, 0, me);
        cmd_op_i = PLACE;
        seat_x_i = 4'd2;
        seat_y_i = 4'd2;
        piece_i = 2'd2;
        xfer = 0;
        dones = 0;
        for (int k = 0; k < 300; k++) begin
            drop = (cmd_valid_i && cmd_ready_o) ? 1 : 0;
            @(negedge clk);
            if (drop != 0) begin
                cmd_valid_i = 1'b0;
                xfer++;
            end
            if (done_o === 1'b1) dones++;
        end
        mdl_apply(PLACE, 2, 2, 2, me);
        chk("hold_valid_transfers", xfer, 1);
        chk("hold_valid_done_pulses", dones, 2);
        chk("hold_valid_count", int'(piece_count_o), mdl_count());
        read_cell(2, 2, v);
        chk("hold_valid_cell", v, 2);

        // Random commands against the board model, concentrated on a corner to force collisions.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 39);
            op = (r == 0) ? 3 : (r < 4) ? 0 : (r < 22) ? 1 : 2;
            if ($urandom_range(0, 9) == 0) begin
                x = $urandom_range(0, 15);
                y = $urandom_range(0, 15);
            end else begin
                x = $urandom_range(0, 4);
                y = $urandom_range(0, 4);
            end
            p = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 2);
            do_cmd(2'(op), x, y, p, e, lat);
            mdl_apply(2'(op), x, y, p, me);
            chk("rnd_err", e, me);
            chk("rnd_latency", lat, (op == 3) ? 225 : 2);
            chk("rnd_count", int'(piece_count_o), mdl_count());
            chk("rnd_last_valid", int'(last_valid_o), m_lv);
            if (m_lv != 0) begin
                chk("rnd_last_x", int'(last_x_o), m_lx);
                chk("rnd_last_y", int'(last_y_o), m_ly);
            end
            rx = $urandom_range(0, 15);
            ry = $urandom_range(0, 15);
            read_cell(rx, ry, v);
            chk("rnd_cell", v, mdl_cell(rx, ry));
        end
        scan_board("final_board");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
